// File: rtl/merge_sort_top.sv
// Three-stage pipelined merge-sort network for eight unsigned WIDTH-bit values.
// Define SORT_DESCENDING_EN to sort descending (y1 = maximum) instead of ascending.
module merge_sort_top #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    input  logic [WIDTH-1:0] x4,
    input  logic [WIDTH-1:0] x5,
    input  logic [WIDTH-1:0] x6,
    input  logic [WIDTH-1:0] x7,
    input  logic [WIDTH-1:0] x8,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y4,
    output logic [WIDTH-1:0] y5,
    output logic [WIDTH-1:0] y6,
    output logic [WIDTH-1:0] y7,
    output logic [WIDTH-1:0] y8
);

    // No handshake: a set is captured on every rising edge and its sorted
    // result is on y1..y8 after the third edge; there is no valid/ready.

    logic [WIDTH-1:0] s1 [8];
    logic [WIDTH-1:0] s2 [8];
    logic [WIDTH-1:0] s3 [8];
    logic [WIDTH-1:0] n1 [8];
    logic [WIDTH-1:0] n2 [8];
    logic [WIDTH-1:0] n3 [8];

    // Compare-exchange: returns {first, second} in output order.
    function automatic logic [2*WIDTH-1:0] cx(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
`ifdef SORT_DESCENDING_EN
        return (a < b) ? {b, a} : {a, b};
`else
        return (a > b) ? {b, a} : {a, b};
`endif
    endfunction

    always_comb begin
        n1 = '{default: '0};
        {n1[0], n1[1]} = cx(x1, x2);
        {n1[2], n1[3]} = cx(x3, x4);
        {n1[4], n1[5]} = cx(x5, x6);
        {n1[6], n1[7]} = cx(x7, x8);
    end

    // Two 2+2 odd-even merges, one per half.
    always_comb begin
        n2 = s1;
        {n2[0], n2[2]} = cx(n2[0], n2[2]);
        {n2[1], n2[3]} = cx(n2[1], n2[3]);
        {n2[1], n2[2]} = cx(n2[1], n2[2]);
        {n2[4], n2[6]} = cx(n2[4], n2[6]);
        {n2[5], n2[7]} = cx(n2[5], n2[7]);
        {n2[5], n2[6]} = cx(n2[5], n2[6]);
    end

    // Batcher 4+4 odd-even merge.
    always_comb begin
        n3 = s2;
        {n3[0], n3[4]} = cx(n3[0], n3[4]);
        {n3[1], n3[5]} = cx(n3[1], n3[5]);
        {n3[2], n3[6]} = cx(n3[2], n3[6]);
        {n3[3], n3[7]} = cx(n3[3], n3[7]);
        {n3[2], n3[4]} = cx(n3[2], n3[4]);
        {n3[3], n3[5]} = cx(n3[3], n3[5]);
        {n3[1], n3[2]} = cx(n3[1], n3[2]);
        {n3[3], n3[4]} = cx(n3[3], n3[4]);
        {n3[5], n3[6]} = cx(n3[5], n3[6]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '{default: '0};
            s2 <= '{default: '0};
            s3 <= '{default: '0};
        end else begin
            s1 <= n1;
            s2 <= n2;
            s3 <= n3;
        end
    end

    assign y1 = s3[0];
    assign y2 = s3[1];
    assign y3 = s3[2];
    assign y4 = s3[3];
    assign y5 = s3[4];
    assign y6 = s3[5];
    assign y7 = s3[6];
    assign y8 = s3[7];

endmodule

// File: tb/tb_merge_sort_top.sv
// Directed and random-sequence bench for merge_sort_top (WIDTH = 6).
module tb_merge_sort_top;
    localparam int W = 6;

    logic clk;
    logic rst;
    logic [8*W-1:0] xv;
    logic [W-1:0] y1, y2, y3, y4, y5, y6, y7, y8;
    logic [8*W-1:0] yall;
    logic [8*W-1:0] exp_q[$];

    int total = 0;
    int bad = 0;

    merge_sort_top #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .x1(xv[0*W +: W]), .x2(xv[1*W +: W]), .x3(xv[2*W +: W]), .x4(xv[3*W +: W]),
        .x5(xv[4*W +: W]), .x6(xv[5*W +: W]), .x7(xv[6*W +: W]), .x8(xv[7*W +: W]),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7), .y8(y8)
    );

    assign yall = {y8, y7, y6, y5, y4, y3, y2, y1};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8*W-1:0] pack8(input int a, input int b, input int c, input int d,
                                             input int e, input int f, input int g, input int h);
        logic [W-1:0] e0, e1, e2, e3, e4, e5, e6, e7;
        e0 = W'(a); e1 = W'(b); e2 = W'(c); e3 = W'(d);
        e4 = W'(e); e5 = W'(f); e6 = W'(g); e7 = W'(h);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    // reference: plain ascending insertion sort
    function automatic logic [8*W-1:0] ref_sort(input logic [8*W-1:0] v);
        logic [W-1:0] a [8];
        logic [W-1:0] t;
        logic [8*W-1:0] r;
        for (int i = 0; i < 8; i++) a[i] = v[i*W +: W];
        for (int i = 1; i < 8; i++)
            for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
                t = a[j]; a[j] = a[j-1]; a[j-1] = t;
            end
        r = '0;
        for (int i = 0; i < 8; i++) r[i*W +: W] = a[i];
        return r;
    endfunction

    function automatic logic [8*W-1:0] rand_set();
        logic [8*W-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
        return r;
    endfunction

    // scoreboard
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // exp is ascending; under descending build y order is reversed
    task automatic check_vec(input string tag, input logic [8*W-1:0] exp);
        int k;
        for (int i = 0; i < 8; i++) begin
`ifdef SORT_DESCENDING_EN
            k = 7 - i;
`else
            k = i;
`endif
            check($sformatf("%s.y%0d", tag, k + 1), yall[k*W +: W], exp[i*W +: W]);
        end
    endtask

    // driver
    task automatic apply(input logic [8*W-1:0] v);
        xv = v;
    endtask

    initial begin
        logic [8*W-1:0] zeros;
        logic [8*W-1:0] exp_v;
        logic [8*W-1:0] basic_exp;
        zeros = '0;

        // reset with arbitrary inputs
        rst = 1'b1;
        apply(rand_set());
        tick();
        check_vec("rst_edge1", zeros);
        apply(rand_set());
        tick();
        check_vec("rst_edge2", zeros);

        // basic vector, release reset
        basic_exp = pack8(1, 2, 4, 5, 7, 8, 45, 51);
        apply(pack8(51, 4, 45, 2, 1, 8, 5, 7));
        rst = 1'b0;
        tick();
        check_vec("post_rst_edge1", zeros);
        tick();
        check_vec("post_rst_edge2", zeros);
        tick();
        check_vec("basic", basic_exp);
        tick();
        check_vec("basic_hold", basic_exp);

        // reverse input
        apply(pack8(63, 62, 61, 60, 59, 58, 57, 56));
        repeat (3) tick();
        check_vec("reverse", pack8(56, 57, 58, 59, 60, 61, 62, 63));

        // already sorted
        apply(pack8(3, 9, 10, 20, 21, 40, 41, 60));
        repeat (3) tick();
        check_vec("sorted", pack8(3, 9, 10, 20, 21, 40, 41, 60));

        // duplicates and extremes
        apply(pack8(0, 63, 0, 63, 63, 0, 63, 0));
        repeat (3) tick();
        check_vec("dup_ext", pack8(0, 0, 0, 0, 63, 63, 63, 63));

        apply(pack8(17, 17, 17, 17, 17, 17, 17, 17));
        repeat (3) tick();
        check_vec("all_eq", pack8(17, 17, 17, 17, 17, 17, 17, 17));

        // back-to-back: new set every edge, result 3 edges later
        for (int i = 0; i < 22; i++) begin
            if (i < 20) begin
                apply(rand_set());
                exp_q.push_back(ref_sort(xv));
            end
            tick();
            if (i >= 2) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b2b queue empty at step %0d", i);
                end else begin
                    exp_v = exp_q.pop_front();
                    check_vec($sformatf("b2b%0d", i - 2), exp_v);
                end
            end
        end
        check(".b2b_left", W'(exp_q.size()), '0);

        // reset mid-stream with three sets in flight
        apply(pack8(60, 50, 40, 30, 20, 10, 5, 1));
        tick();
        apply(pack8(33, 33, 12, 12, 44, 44, 55, 55));
        tick();
        apply(pack8(7, 6, 5, 4, 3, 2, 1, 62));
        tick();
        rst = 1'b1;
        apply(pack8(9, 9, 9, 9, 9, 9, 9, 9));
        tick();
        check_vec("mid_rst", zeros);
        rst = 1'b0;
        apply(pack8(2, 1, 4, 3, 6, 5, 8, 7));
        tick();
        check_vec("flush1", zeros);
        tick();
        check_vec("flush2", zeros);
        tick();
        check_vec("after_flush", pack8(1, 2, 3, 4, 5, 6, 7, 8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
